// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// producers.
//
// Each granted beat appears on the FIFO write side one cycle later as
// registered write_en/data_in. A grant can hold for up to MAX_BURST
// consecutive beats before the requesters are re-arbitrated.
//
// A mirrored occupancy count (occ) keeps the arbiter from overrunning the
// FIFO. The FIFO error flag halts the arbiter until reset.
//
// Optional feature (macro FIFO_ARB_STATS_EN):
//   Adds the saturating 16-bit counters beat_cnt and stall_cnt.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   req        in   [NUM_REQ]  per-requester write request (level)
//   req_data   in   [NUM_REQ*DATA_W]  slice i = [i*DATA_W +: DATA_W]
//   grant      out  [NUM_REQ]  one-hot combinational grant
//   full       in   FIFO full flag
//   empty      in   FIFO empty flag
//   error      in   FIFO error flag
//   read_en    in   FIFO read enable (observed for credit tracking)
//   write_en   out  registered FIFO write enable
//   data_in    out  [DATA_W]  registered FIFO write data
//   owner      out  index of current/last granted requester
//   halted     out  sticky error-halt indicator
//   state_dbg  out  [2]  FSM state (0 idle, 1 burst, 2 halt)
//   beat_cnt   out  [16]  accepted beats        (FIFO_ARB_STATS_EN only)
//   stall_cnt  out  [16]  requested-but-idle cycles (FIFO_ARB_STATS_EN only)
//
// Handshake:
//   A beat from requester i is accepted in a cycle where req[i] && grant[i].
//   A requester keeps req and its data slice stable until it sees that
//   acceptance. It may change either one in the following cycle.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    input  logic                         full,
    input  logic                         empty,
    input  logic                         error,
    input  logic                         read_en,
    output logic                         write_en,
    output logic [DATA_W-1:0]            data_in,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         halted,
    output logic [1:0]                   state_dbg
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                  beat_cnt,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int OWN_W  = $clog2(NUM_REQ);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state;
    logic [OCC_W-1:0]    occ;
    logic [BEAT_W-1:0]   beats;
    logic [BEAT_W-1:0]   beats_inc;

    logic                credit_ok;
    logic [OCC_W:0]      occ_pend;
    logic                occ_dec;

    logic                rr_found;
    logic [OWN_W-1:0]    rr_idx;
    logic [OWN_W-1:0]    rr_cand;

    logic                accept;
    logic [OWN_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   slice [NUM_REQ];

    assign state_dbg = state;
    assign beats_inc = beats + BEAT_W'(1);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*DATA_W +: DATA_W];
    end

    // The beat already registered in write_en counts against the credit.
    // A read in the same cycle does not add credit yet.
    assign occ_pend  = {1'b0, occ} + {{OCC_W{1'b0}}, write_en};
    assign credit_ok = !full && (occ_pend < (OCC_W+1)'(FIFO_DEPTH));
    assign occ_dec   = read_en && !empty && (occ != '0);

    // Round-robin search starting one past the last owner.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = OWN_W'((int'(owner) + k) % NUM_REQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Combinational grant. It is killed outright by the halt state or by
    // the error flag itself. credit_ok already folds in the FIFO full flag.
    always_comb begin
        grant   = '0;
        accept  = 1'b0;
        sel_idx = owner;
        if (state != ST_HALT && !error && credit_ok) begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant[rr_idx] = 1'b1;
                        accept        = 1'b1;
                        sel_idx       = rr_idx;
                    end
                end
                ST_BURST: begin
                    if (req[owner] && (beats < BEAT_W'(MAX_BURST))) begin
                        grant[owner] = 1'b1;
                        accept       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arbitration FSM plus the registered write side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_W'(NUM_REQ - 1);
            beats    <= '0;
            write_en <= 1'b0;
            data_in  <= '0;
            halted   <= 1'b0;
        end else if (error || state == ST_HALT) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            write_en <= 1'b0;
        end else begin
            write_en <= accept;
            if (accept) begin
                data_in <= slice[sel_idx];
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner <= rr_idx;
                        beats <= BEAT_W'(1);
                        if (MAX_BURST > 1) begin
                            state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    // A dropped request ends the burst. The handover
                    // waits for the next cycle's arbitration.
                    if (!req[owner]) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        beats <= beats_inc;
                        if (beats_inc == BEAT_W'(MAX_BURST)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Mirrored FIFO occupancy. A write and a read in the same cycle cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (write_en && !occ_dec) begin
            if (occ != OCC_W'(FIFO_DEPTH)) begin
                occ <= occ + OCC_W'(1);
            end
        end else if (occ_dec && !write_en) begin
            occ <= occ - OCC_W'(1);
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && beat_cnt != 16'hFFFF) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if ((|req) && !(|grant) && state != ST_HALT
                && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit FIFO write port among NUM_REQ producers.
- Sits between the producer blocks and the FIFO write side.
- Drives write_en/data_in from registers.
- Keeps a mirrored occupancy count so it never overruns the FIFO.
- Halts on the FIFO error flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data width, equal to the FIFO data width
- FIFO_DEPTH, 16, FIFO entry count, used for credit tracking
- MAX_BURST, 4, maximum consecutive beats per grant before re-arbitration (>=1)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester write request, level, held until granted
- req_data  in  NUM_REQ*DATA_W  packed requester data; slice i is [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot combinational grant; beat i accepted when req[i]&&grant[i]
- full  in  1  FIFO full flag
- empty  in  1  FIFO empty flag
- error  in  1  FIFO error flag
- read_en  in  1  FIFO read enable, observed for credit tracking
- write_en  out  1  registered FIFO write enable
- data_in  out  DATA_W  registered FIFO write data
- owner  out  $clog2(NUM_REQ)  index of current/last granted requester
- halted  out  1  sticky error-halt indicator

Behaviour:
Reset values:
- grant=0, write_en=0, data_in=0, owner=NUM_REQ-1, halted=0
- state=IDLE, occ=0, beat count=0
- First arbitration favours requester 0.

Credit:
- occ counter, width $clog2(FIFO_DEPTH+1).
- +1 on each cycle with write_en=1.
- -1 on read_en&&!empty&&occ!=0.
- Both in one cycle: unchanged.
- credit_ok = !full && (occ + write_en) < FIFO_DEPTH. Conservative: a same-cycle read does not add credit.

Latency:
- Beat accepted in cycle k appears as write_en=1, data_in=req_data slice in cycle k+1.
- One beat per cycle maximum.

States:
- IDLE:
  - If credit_ok and any req, pick the first set req searching owner+1, owner+2, … modulo NUM_REQ.
  - Assert that grant this cycle and set owner.
  - Beat count=1; go to BURST, or stay IDLE if MAX_BURST==1.
  - No req or no credit: grant=0, stay.
- BURST:
  - If req[owner] && credit_ok && beats<MAX_BURST: grant[owner]=1, beats+1.
  - When beats reaches MAX_BURST after this accept, go to IDLE.
  - If req[owner]=0: grant=0, go to IDLE. Re-arbitrate next cycle; no same-cycle handover.
  - If credit_ok=0 and req[owner]=1: grant=0, stay in BURST, owner retained, beats unchanged.
- HALT:
  - Entered from any state on error=1 sampled at a clock edge.
  - grant forced 0 combinationally whenever state==HALT or error==1.
  - write_en=0 from the next cycle; halted=1.
  - Stays in HALT until rst.
  - occ still tracks reads.

Grant rules:
- grant is never asserted for a requester whose req=0.
- grant is at most one-hot.
- grant never asserted while full=1.

Boundaries:
- occ saturates at FIFO_DEPTH and at 0; never wraps.
- Round-robin pointer wraps NUM_REQ-1 -> 0.
- Requester data must stay stable while req=1 and un-granted.
- rst mid-burst: immediate return to reset values. A pending write_en is dropped.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output beat_cnt (16 bits), counting accepted beats (|grant&req).
  - Saturates at 16'hFFFF; cleared by rst.
  - Adds output stall_cnt (16 bits), counting cycles with |req=1 and grant=0 outside HALT, same saturation and clearing.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Fairness: req=4'b1111 continuously, MAX_BURST=4, no reads -> grants go to 0 for 4 beats, then 1, then 2, then 3. Stall after 16 writes (occ=16). write_en is one cycle behind each grant.
- Credit limit: FIFO_DEPTH=16, req[2] only, read_en=0 -> exactly 16 write_en pulses. grant=0 thereafter; no write while full=1.
- Credit resume: from occ=16, one read_en with empty=0 -> occ=15, next cycle grant[2]=1, write_en pulse the following cycle.
- Burst break: req[1]=1 for 2 cycles then 0, req[3]=1 -> 2 beats from 1, one idle cycle, then grant[3]=1.
- Error halt: error pulsed 1 cycle mid-burst -> grant=0 in that cycle, halted=1 after the edge. No write_en until rst; rst restores owner=NUM_REQ-1, occ=0.
- Data path: req_data slice 0=8'hA5, req[0] granted in cycle k -> data_in=8'hA5 with write_en=1 in cycle k+1.
